snake_move_collide: RTL and testbench
=====================================

Name: snake_move_collide

Overview:
- Snake movement and collision engine; sits directly upstream of the game-state controller.
- Holds head and body segment coordinates, steps the snake once per move tick, and applies direction keys with reversal rejection.
- Raises single-cycle dead_wall / dead_it pulses that the controller consumes.
- Reinitialises the snake when the controller reports the dead state.

Parameters:
- GRID_W, 40, playfield width in cells; x range 0..GRID_W-1.
- GRID_H, 30, playfield height in cells; y range 0..GRID_H-1.
- MAX_LEN, 16, segment storage depth; length saturates here.
- INIT_LEN, 3, length after reset or restart; must be 2..MAX_LEN.
- TICK_DIV, 12500000, clk cycles per move step; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- dir_key  in  4  one-hot request {up,down,left,right}, level, synchronous to clk.
- grow  in  1  food-eaten pulse; extends the snake on the next move.
- game_status  in  2  from controller; 2'b00 start, 2'b10 dead.
- seg_idx  in  $clog2(MAX_LEN)  body read index for the display.
- seg_x  out  XW  x of segment seg_idx, combinational read; XW=$clog2(GRID_W).
- seg_y  out  YW  y of segment seg_idx, combinational read; YW=$clog2(GRID_H).
- head_x  out  XW  segment 0 x.
- head_y  out  YW  segment 0 y.
- snake_len  out  $clog2(MAX_LEN+1)  current length.
- move_tick  out  1  one-cycle pulse on every move step.
- dead_wall  out  1  one-cycle pulse: next head would leave the grid.
- dead_it  out  1  one-cycle pulse: next head hits own body.

Behaviour:
- Reset (async):
  - tick counter 0; dir=RIGHT; pending_grow 0; state RUN.
  - Segment i = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN; other segments 0.
  - snake_len=INIT_LEN; move_tick, dead_wall, dead_it = 0.
- Tick: counter runs 0..TICK_DIV-1; the wrap cycle pulses move_tick (registered). The counter runs in every state; moves act only in RUN.
- Direction, sampled every cycle in RUN:
  - Exactly one dir_key bit set and not opposite to the last *applied* dir: latch into dir_req.
  - Zero keys, multiple keys, or reversal: ignored.
  - dir := dir_req at each move.
- grow sets pending_grow; it stays set until consumed by a move. A second grow before the move is absorbed (one increment).
- State RUN, on move tick:
  - Compute next head from dir (±1 on x or y).
  - Wall: x<0, x>GRID_W-1, y<0 or y>GRID_H-1 → dead_wall=1 next cycle, no shift, go FROZEN.
  - Self: otherwise, compare next head to segments 0..len-2 (0..len-1 if pending_grow). Any match → dead_it=1 next cycle, no shift, go FROZEN.
  - Wall check has priority; both pulses never assert together.
  - Else shift: seg[i]<=seg[i-1], seg[0]<=next head.
  - If pending_grow and len<MAX_LEN: len+1 and clear pending_grow.
  - If pending_grow and len==MAX_LEN: clear pending_grow, length unchanged.
- State FROZEN: no moves, keys and grow ignored; wait for game_status==2'b10.
- State REINIT, entered when dead is seen:
  - One cycle: load reset geometry, dir=RIGHT, pending_grow 0.
  - Then WAIT_START until game_status==2'b00, then RUN.
  - The counter is not cleared, so the first move occurs at the next natural tick.
- game_status==2'b10 while in RUN (external kill) also goes to REINIT.
- Collision pulses are registered; the controller sees its dead state 3 clk later.

Optional Feature:
- Macro WRAP_WALL_EN.
- Defined: walls wrap instead of killing.
  - x=-1→GRID_W-1, x=GRID_W→0; same for y.
  - dead_wall is tied 0; the self check uses the wrapped head.
- Undefined: wall collision as above.

Decomposition:
- Package snake_pkg:
  - dir_t enum {UP,DOWN,LEFT,RIGHT} plus opposite() function.
  - GAME_START=2'b00, GAME_DEAD=2'b10.
  - Grid defaults and width localparams.
- Sub-module snake_tick_gen: TICK_DIV counter producing move_tick.

Test Plan (TICK_DIV=4, GRID 8x8, MAX_LEN=4, INIT_LEN=3):
- Reset, no keys → head (4,4), body (3,4),(2,4); after 3 ticks head (7,4); 4th tick dead_wall one cycle, head stays (7,4).
- Press left while moving right → ignored; press up → next move head y-1, dir UP applied.
- grow pulse, then one tick → snake_len 3→4; two more grows and ticks → stays 4 (saturate).
- len 4, path right, down, left, up into own body → dead_it one cycle, dead_wall 0, no shift.
- After collision, drive game_status 2'b10 then 2'b00 → geometry back to reset values, moves resume on next tick.
- With WRAP_WALL_EN defined, head (7,4) moving right → (0,4), no dead_wall.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake movement/collision engine.
package snake_pkg;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [1:0] {RUN, FROZEN, REINIT, WAIT_START} state_t;

    localparam logic [1:0] GAME_START = 2'b00;
    localparam logic [1:0] GAME_DEAD  = 2'b10;

    localparam int GRID_W_DEF   = 40;
    localparam int GRID_H_DEF   = 30;
    localparam int MAX_LEN_DEF  = 16;
    localparam int INIT_LEN_DEF = 3;
    localparam int TICK_DIV_DEF = 12500000;

    // Direction that would fold the head back onto the neck.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      opposite = DOWN;
            DOWN:    opposite = UP;
            LEFT:    opposite = RIGHT;
            default: opposite = LEFT;
        endcase
    endfunction

    // Decode a one-hot {up,down,left,right} key vector; caller checks one-hotness.
    function automatic dir_t key_dir(input logic [3:0] k);
        case (k)
            4'b1000: key_dir = UP;
            4'b0100: key_dir = DOWN;
            4'b0010: key_dir = LEFT;
            default: key_dir = RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Free-running move-step divider: one registered pulse every TICK_DIV clocks.
module snake_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    output logic move_tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1; the wrap cycle raises move_tick on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            move_tick <= 1'b0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt       <= '0;
            move_tick <= 1'b1;
        end else begin
            cnt       <= cnt + CW'(1);
            move_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_move_collide.sv
// Snake movement and collision engine. Steps the snake each move tick,
// applies direction keys with reversal rejection, and reports wall/self hits.
// Optional build macro: WRAP_WALL_EN (walls wrap around instead of killing).
module snake_move_collide
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF,
    parameter int INIT_LEN = INIT_LEN_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int IW = $clog2(MAX_LEN),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    dir_key,
    input  logic          grow,
    input  logic [1:0]    game_status,
    input  logic [IW-1:0] seg_idx,
    output logic [XW-1:0] seg_x,
    output logic [YW-1:0] seg_y,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] snake_len,
    output logic          move_tick,
    output logic          dead_wall,
    output logic          dead_it
);
    typedef logic [MAX_LEN-1:0][XW-1:0] segx_t;
    typedef logic [MAX_LEN-1:0][YW-1:0] segy_t;

    function automatic segx_t init_x();
        init_x = '0;
        for (int i = 0; i < INIT_LEN; i++) init_x[i] = XW'(GRID_W / 2 - i);
    endfunction

    function automatic segy_t init_y();
        init_y = '0;
        for (int i = 0; i < INIT_LEN; i++) init_y[i] = YW'(GRID_H / 2);
    endfunction

    localparam segx_t INIT_X = init_x();
    localparam segy_t INIT_Y = init_y();

    segx_t         sx;
    segy_t         sy;
    dir_t          dir, dir_req, ref_dir;
    state_t        state, state_nx;
    logic          pend;
    logic [LW-1:0] len;
    logic [XW-1:0] nhx;
    logic [YW-1:0] nhy;
    logic          wall, hit, do_move, shift_ok, key_ok;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .move_tick (move_tick)
    );

    assign do_move  = (state == RUN) && move_tick && (game_status != GAME_DEAD);
    assign shift_ok = do_move && !wall && !hit;
    // On a move cycle the pending request becomes the applied direction.
    assign ref_dir  = do_move ? dir_req : dir;
    assign key_ok   = (state == RUN) && $onehot(dir_key) && (key_dir(dir_key) != opposite(ref_dir));

    // Next head position from the requested direction, with wall detect (or wrap).
    always_comb begin
        int nx, ny;
        nx   = int'(sx[0]);
        ny   = int'(sy[0]);
        case (dir_req)
            UP:      ny = ny - 1;
            DOWN:    ny = ny + 1;
            LEFT:    nx = nx - 1;
            default: nx = nx + 1;
        endcase
        wall = (nx < 0) || (nx > GRID_W - 1) || (ny < 0) || (ny > GRID_H - 1);
`ifdef WRAP_WALL_EN
        if (nx < 0)          nx = GRID_W - 1;
        if (nx > GRID_W - 1) nx = 0;
        if (ny < 0)          ny = GRID_H - 1;
        if (ny > GRID_H - 1) ny = 0;
        wall = 1'b0;
`endif
        nhx = XW'(nx);
        nhy = YW'(ny);
    end

    // Self hit: the tail cell is vacated by the shift unless the snake grows.
    always_comb begin
        int lim;
        lim = pend ? int'(len) : int'(len) - 1;
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < lim && sx[i] == nhx && sy[i] == nhy) hit = 1'b1;
    end

    // Game-phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // Next-state: collisions freeze, dead status restarts, start status resumes.
    always_comb begin
        state_nx = state;
        case (state)
            RUN: begin
                if (game_status == GAME_DEAD)  state_nx = REINIT;
                else if (do_move && (wall || hit)) state_nx = FROZEN;
            end
            FROZEN:     if (game_status == GAME_DEAD) state_nx = REINIT;
            REINIT:     state_nx = WAIT_START;
            WAIT_START: if (game_status == GAME_START) state_nx = RUN;
            default:    state_nx = RUN;
        endcase
    end

    // Segment storage, direction, growth and collision pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx        <= INIT_X;
            sy        <= INIT_Y;
            dir       <= RIGHT;
            dir_req   <= RIGHT;
            pend      <= 1'b0;
            len       <= LW'(INIT_LEN);
            dead_wall <= 1'b0;
            dead_it   <= 1'b0;
        end else begin
            dead_wall <= do_move && wall;
            dead_it   <= do_move && !wall && hit;
            if (state == REINIT) begin
                sx      <= INIT_X;
                sy      <= INIT_Y;
                dir     <= RIGHT;
                dir_req <= RIGHT;
                pend    <= 1'b0;
                len     <= LW'(INIT_LEN);
            end else begin
                if (key_ok)  dir_req <= key_dir(dir_key);
                if (do_move) dir     <= dir_req;
                if (shift_ok) begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        sx[i] <= sx[i-1];
                        sy[i] <= sy[i-1];
                    end
                    sx[0] <= nhx;
                    sy[0] <= nhy;
                    if (pend && int'(len) < MAX_LEN) len <= len + LW'(1);
                    pend <= grow;
                end else if (state == RUN && grow) begin
                    pend <= 1'b1;
                end
            end
        end
    end

    assign head_x    = sx[0];
    assign head_y    = sy[0];
    assign snake_len = len;
    assign seg_x     = (int'(seg_idx) < MAX_LEN) ? sx[seg_idx] : '0;
    assign seg_y     = (int'(seg_idx) < MAX_LEN) ? sy[seg_idx] : '0;

endmodule

// File: tb/tb_snake_move_collide.sv
// Directed bench for snake_move_collide on an 8x8 grid, 4-cycle ticks, max length 4.
module tb_snake_move_collide;
    localparam int GW = 8, GH = 8, ML = 4, IL = 3, TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dir_key;
    logic       grow;
    logic [1:0] game_status;
    logic [1:0] seg_idx;
    logic [2:0] seg_x, seg_y, head_x, head_y;
    logic [2:0] snake_len;
    logic       move_tick, dead_wall, dead_it;

    localparam logic [3:0] K_UP = 4'b1000, K_DN = 4'b0100, K_LT = 4'b0010, K_RT = 4'b0001;

    snake_move_collide #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .dir_key(dir_key), .grow(grow), .game_status(game_status),
        .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .head_x(head_x), .head_y(head_y),
        .snake_len(snake_len), .move_tick(move_tick), .dead_wall(dead_wall), .dead_it(dead_it)
    );

    always #5 clk = ~clk;

    typedef struct {int hx; int hy; int len; int dw; int di;} exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int hx, input int hy, input int len, input int dw, input int di);
        exp_t e;
        e.hx = hx; e.hy = hy; e.len = len; e.dw = dw; e.di = di;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] k, input logic g);
        dir_key = k; grow = g;
        @(negedge clk);
        dir_key = 4'b0; grow = 1'b0;
    endtask

    task automatic check_seg(input string tag, input logic [1:0] idx, input int x, input int y);
        seg_idx = idx;
        #1;
        check({tag, "_x"}, seg_x, x);
        check({tag, "_y"}, seg_y, y);
    endtask

    // Wait for a move tick, then compare the result of that move with the scoreboard.
    task automatic wait_move(input string tag);
        int n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!move_tick && n < 40);
        if (!move_tick) begin
            tests++; fails++;
            $error("FAIL %s_timeout: observed no move_tick expected move_tick within 40 cycles", tag);
        end
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_hx"}, head_x, e.hx);
        check({tag, "_hy"}, head_y, e.hy);
        check({tag, "_len"}, snake_len, e.len);
        check({tag, "_dw"}, dead_wall, e.dw);
        check({tag, "_di"}, dead_it, e.di);
        @(negedge clk);
        check({tag, "_dw_end"}, dead_wall, 0);
        check({tag, "_di_end"}, dead_it, 0);
    endtask

    task automatic check_reset_geom(input string tag);
        check({tag, "_hx"}, head_x, 4);
        check({tag, "_hy"}, head_y, 4);
        check({tag, "_len"}, snake_len, 3);
        check_seg({tag, "_s1"}, 2'd1, 3, 4);
        check_seg({tag, "_s2"}, 2'd2, 2, 4);
        check_seg({tag, "_s3"}, 2'd3, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; dir_key = 4'b0; grow = 1'b0; game_status = 2'b00; seg_idx = 2'd0;
        #12;
        check_reset_geom("rst");
        check("rst_tick", move_tick, 0);
        check("rst_dw", dead_wall, 0);
        check("rst_di", dead_it, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Run right into the east wall.
        push(5, 4, 3, 0, 0); wait_move("mv1");
        push(6, 4, 3, 0, 0); wait_move("mv2");
        push(7, 4, 3, 0, 0); wait_move("mv3");
`ifdef WRAP_WALL_EN
        push(0, 4, 3, 0, 0); wait_move("wrap");
`else
        push(7, 4, 3, 1, 0); wait_move("wall");
        repeat (5) @(negedge clk);
        check("frozen_hx", head_x, 7);
        check("frozen_hy", head_y, 4);
`endif

        // Dead then start: geometry restored.
        game_status = 2'b10;
        repeat (3) @(negedge clk);
        check_reset_geom("reinit1");
        game_status = 2'b00;

        // Reversal ignored, turn accepted, then reversal of the new direction ignored.
        drive(K_LT, 1'b0); push(5, 4, 3, 0, 0); wait_move("rev_rt");
        drive(K_UP, 1'b0); push(5, 3, 3, 0, 0); wait_move("turn_up");
        drive(K_DN, 1'b0); push(5, 2, 3, 0, 0); wait_move("rev_up");

        // Growth and saturation at MAX_LEN.
        drive(4'b0, 1'b1); push(5, 1, 4, 0, 0); wait_move("grow1");
        drive(4'b0, 1'b1); push(5, 0, 4, 0, 0); wait_move("grow_sat1");
        drive(K_RT, 1'b1); push(6, 0, 4, 0, 0); wait_move("grow_sat2");

        // Square path back into the tail while growing: self collision, no shift.
        drive(K_DN, 1'b0); push(6, 1, 4, 0, 0); wait_move("sq_dn");
        drive(K_LT, 1'b0); push(5, 1, 4, 0, 0); wait_move("sq_lt");
        drive(K_UP, 1'b1); push(5, 1, 4, 0, 1); wait_move("self");
        check_seg("self_s1", 2'd1, 6, 1);

        // Restart and resume on the next natural tick heading right.
        game_status = 2'b10;
        repeat (3) @(negedge clk);
        check_reset_geom("reinit2");
        game_status = 2'b00;
        push(5, 4, 3, 0, 0); wait_move("resume");

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
